// File: rtl/audio_pkg.sv
// Shared defaults and the stereo pair type for the audio DAC serializer.
package audio_pkg;

  localparam int SAMPLE_W_DEF    = 16;
  localparam int HALF_PERIOD_DEF = 125;
  localparam int BIT_DIV_DEF     = 4;
  localparam int FIFO_DEPTH_DEF  = 4;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo pairs with a show-ahead read port and occupancy count.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified stereo DAC serializer fed from a pair FIFO; one frame per 2*HALF_PERIOD clocks.
// Optional underrun_count output enabled by defining AUDIO_DAC_UNDERRUN_CNT_EN.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int BIT_DIV     = BIT_DIV_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           sample_left,
  input  logic [SAMPLE_W-1:0]           sample_right,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          aud_bclk,
  output logic                          aud_daclrck,
  output logic                          aud_dacdat,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int HW = $clog2(HALF_PERIOD);
  localparam int PW = $clog2(BIT_DIV);
  localparam logic [HW-1:0] H_LAST  = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(BIT_DIV - 1);
  localparam logic [PW-1:0] P_HIGH  = PW'(BIT_DIV / 2);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  // r_h counts down through the half-frame, r_ph down through one serial bit.
  logic [HW-1:0]       r_h;
  logic [PW-1:0]       r_ph;
  logic                r_right_half;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_right_hold;
  logic                r_bclk;
  logic                r_lrck;
  logic                r_dat;
  logic                r_underrun;

  logic [LW-1:0]       w_level;
  logic                w_ready;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_frame_start;
  logic                w_right_start;
  pair_t               w_pair_in;
  pair_t               w_fifo_out;
  pair_t               w_load;
  logic [SAMPLE_W-1:0] w_cur;

  assign w_pair_in = '{left: sample_left, right: sample_right};
  assign w_ready   = (w_level < DEPTH_L);
  assign w_empty   = (w_level == '0);
  assign w_push    = sample_valid && w_ready;

  sample_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_pair_in),
    .o_rd_data (w_fifo_out),
    .o_level   (w_level)
  );

  always_comb begin
    w_frame_start = !r_right_half && (r_h == H_LAST);
    w_right_start = r_right_half && (r_h == H_LAST);
    w_pop         = w_frame_start && !w_empty;
    w_load        = w_empty ? '0 : w_fifo_out;
    w_cur         = r_shift;
    // The word driving this cycle's bit is loaded in the same cycle it is first used.
    if (w_frame_start) begin
      w_cur = w_load.left;
    end else if (w_right_start) begin
      w_cur = r_right_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h          <= H_LAST;
      r_ph         <= P_LAST;
      r_right_half <= 1'b0;
      r_shift      <= '0;
      r_right_hold <= '0;
      r_bclk       <= 1'b0;
      r_lrck       <= 1'b0;
      r_dat        <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_h          <= (r_h == '0) ? H_LAST : r_h - 1'b1;
      r_right_half <= r_right_half ^ (r_h == '0);
      r_ph         <= ((r_h == '0) || (r_ph == '0)) ? P_LAST : r_ph - 1'b1;
      r_shift      <= (r_ph == '0) ? {w_cur[SAMPLE_W-2:0], 1'b0} : w_cur;
      if (w_frame_start) begin
        r_right_hold <= w_load.right;
      end
      r_bclk       <= (r_ph < P_HIGH);
      r_lrck       <= !r_right_half;
      r_dat        <= w_cur[SAMPLE_W-1];
      r_underrun   <= w_frame_start && w_empty;
    end
  end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  logic [15:0] r_und_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_und_cnt <= '0;
    end else if (w_frame_start && w_empty && (r_und_cnt != 16'hFFFF)) begin
      r_und_cnt <= r_und_cnt + 16'd1;
    end
  end

  assign underrun_count = r_und_cnt;
`endif

  assign sample_ready = w_ready;
  assign fifo_level   = w_level;
  assign aud_bclk     = r_bclk;
  assign aud_daclrck  = r_lrck;
  assign aud_dacdat   = r_dat;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: queue-based frame model plus directed literal checks.
module tb_audio_dac_serializer;
  import audio_pkg::*;

  localparam int SW    = 16;
  localparam int HP    = 125;
  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 2 * HP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        underrun;
  logic [2:0]  fifo_level;
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  audio_dac_serializer #(
    .SAMPLE_W    (SW),
    .HALF_PERIOD (HP),
    .BIT_DIV     (BD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: the FIFO as a queue, the pair being played, and the frame position.
  stereo_sample_t m_q[$];
  stereo_sample_t m_cur;
  int             m_fc = 0;
  int             m_und_cnt = 0;
  int             h, b;
  bit             do_push;
  logic [15:0]    cs;
  logic           e_bclk, e_lr, e_dat, e_und;
  int             e_level = 0;

  // Bit capture on observed bclk rising edges; snapshot at each frame-clock rise.
  logic [31:0] cap_l = '0, cap_r = '0, done_l = '0, done_r = '0;
  logic        prev_lr = 1'b0, prev_bclk = 1'b0;
  int          snap_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_cur     = '0;
      m_fc      = 0;
      m_und_cnt = 0;
      e_bclk = 0; e_lr = 0; e_dat = 0; e_und = 0;
      e_level   = 0;
    end else begin
      do_push = sample_valid && (m_q.size() < DEPTH);
      e_und   = 1'b0;
      if (m_fc == 0) begin
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
        end else begin
          m_cur = '0;
          e_und = 1'b1;
          if (m_und_cnt < 65535) m_und_cnt++;
        end
      end
      if (do_push) m_q.push_back('{left: sample_left, right: sample_right});
      h      = m_fc % HP;
      b      = h / BD;
      e_lr   = (m_fc < HP);
      e_bclk = ((h % BD) >= BD / 2);
      cs     = e_lr ? m_cur.left : m_cur.right;
      e_dat  = (b < SW) ? cs[SW-1-b] : 1'b0;
      m_fc   = (m_fc + 1) % FRAME;
      e_level = m_q.size();
    end
    #1;
    check("level", 32'(fifo_level), 32'(e_level));
    check("ready", 32'(sample_ready), 32'(e_level < DEPTH));
    check("bclk", 32'(aud_bclk), 32'(e_bclk));
    check("lrck", 32'(aud_daclrck), 32'(e_lr));
    check("dacdat", 32'(aud_dacdat), 32'(e_dat));
    check("underrun", 32'(underrun), 32'(e_und));
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    check("underrun_count", 32'(underrun_count), 32'(m_und_cnt));
`endif
    if (reset) begin
      cap_l = '0; cap_r = '0; prev_lr = 1'b0; prev_bclk = 1'b0;
    end else begin
      if (!prev_lr && aud_daclrck) begin
        done_l = cap_l; done_r = cap_r; cap_l = '0; cap_r = '0;
        snap_cnt++;
      end
      if (aud_bclk && !prev_bclk) begin
        if (aud_daclrck) cap_l = {cap_l[30:0], aud_dacdat};
        else             cap_r = {cap_r[30:0], aud_dacdat};
      end
      prev_lr   = aud_daclrck;
      prev_bclk = aud_bclk;
    end
  end

  task automatic wait_fc(input int target);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (m_fc == target) return;
    end
    errors++;
    $display("FAIL wait_fc timeout target=%0d", target);
  endtask

  task automatic wait_snaps(input int target);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (snap_cnt >= target) return;
    end
    errors++;
    $display("FAIL wait_snaps timeout actual=%0d required=%0d", snap_cnt, target);
  endtask

  int und_n, lr_n, dat_n, s0;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_lrck", 32'(aud_daclrck), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;

    // Idle: two frames with nothing pushed.
    und_n = 0; lr_n = 0; dat_n = 0;
    repeat (500) begin
      @(negedge clk);
      und_n += int'(underrun);
      lr_n  += int'(aud_daclrck);
      dat_n += int'(aud_dacdat);
    end
    check("idle_underruns", 32'(und_n), 32'd2);
    check("idle_lrck_high", 32'(lr_n), 32'd250);
    check("idle_dacdat_ones", 32'(dat_n), 32'd0);

    // Single pair pushed mid-frame, played in the next frame.
    wait_fc(10);
    sample_left = 16'h8001; sample_right = 16'h7FFE; sample_valid = 1'b1;
    s0 = snap_cnt;
    @(negedge clk);
    sample_valid = 1'b0;
    check("pair_level", 32'(fifo_level), 32'd1);
    wait_snaps(s0 + 2);
    check("pair_left_bits", done_l, 32'h4000_8000);
    check("pair_right_bits", done_r, 32'h3FFF_0000);

    // Push coinciding with frame start into an empty FIFO.
    wait_fc(0);
    sample_left = 16'h1234; sample_right = 16'hABCD; sample_valid = 1'b1;
    s0 = snap_cnt;
    @(negedge clk);
    sample_valid = 1'b0;
    check("coincide_underrun", 32'(underrun), 32'd1);
    check("coincide_level", 32'(fifo_level), 32'd1);
    wait_snaps(s0 + 2);
    check("coincide_zero_left", done_l, 32'd0);
    check("coincide_zero_right", done_r, 32'd0);
    wait_snaps(s0 + 3);
    check("coincide_left_bits", done_l, 32'h091A_0000);
    check("coincide_right_bits", done_r, 32'h55E6_8000);

    // Hold valid until full, across a frame start.
    wait_fc(20);
    sample_left = 16'h5A5A; sample_right = 16'hA5A5; sample_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(sample_ready), 32'd0);
    wait_fc(5);
    check("full_after_pop_level", 32'(fifo_level), 32'd4);
    sample_valid = 1'b0;

    // Reset mid-frame with three pairs queued.
    wait_fc(0);
    wait_fc(60);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_ready", 32'(sample_ready), 32'd1);
    check("midrst_bclk", 32'(aud_bclk), 32'd0);
    check("midrst_lrck", 32'(aud_daclrck), 32'd0);
    check("midrst_dacdat", 32'(aud_dacdat), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_lrck", 32'(aud_daclrck), 32'd1);
    check("post_rst_underrun", 32'(underrun), 32'd1);
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    repeat (500) @(negedge clk);
    check("underrun_count_3", 32'(underrun_count), 32'd3);
`else
    repeat (20) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
